// File: rtl/multicycle_seq.sv
// ============================================================================
// Module   : multicycle_seq
// Purpose  : Multicycle CPU control sequencer (fetch/decode/exec/mem/wb) with
//            shared-memory handshake, ack timeout and sticky halt/error flags.
//            Optional macro PERF_CNT_EN adds the retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_seq #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic        dec_rf_wen,
   input  logic        dec_dram_wen,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_wen,
   output logic        pc_wen,
   output logic        rf_wen,
   output logic [2:0]  state,
   output logic        halted,
   output logic        err,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

   localparam int c_CNT_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam int c_LIMIT_I = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(c_LIMIT_I);

   state_t             r_state;
   state_t             w_next;
   logic [c_CNT_W-1:0] r_wait_cnt;
   logic               r_halted;
   logic               r_err;
   logic               w_timeout;

   // The count holds the number of un-acked request cycles already spent, so
   // the cycle in which it equals ACK_TIMEOUT-1 is the last one allowed.
   assign w_timeout = (ACK_TIMEOUT != 0) && !mem_ack && (r_wait_cnt == c_LIMIT);

   always_comb begin
      w_next       = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_wen       = 1'b0;
      pc_wen       = 1'b0;
      rf_wen       = 1'b0;
      case (r_state)
         S_BOOT: w_next = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_wen = 1'b1;
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_DECODE: w_next = (opcode == c_OP_SYSTEM) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (opcode == c_OP_LOAD || opcode == c_OP_STORE) begin
               w_next = S_MEM;
            end else if (opcode == c_OP_BRANCH) begin
               pc_wen = 1'b1;
               w_next = S_FETCH;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = dec_dram_wen;
            if (mem_ack) begin
               pc_wen = dec_dram_wen;
               w_next = dec_dram_wen ? S_FETCH : S_WB;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_WB: begin
            rf_wen = dec_rf_wen;
            pc_wen = 1'b1;
            w_next = S_FETCH;
         end
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_BOOT;
         r_wait_cnt <= '0;
         r_halted   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= (mem_req && !mem_ack && w_next == r_state) ?
                       r_wait_cnt + 1'b1 : '0;
         r_halted   <= r_halted | (w_next == S_HALT);
         r_err      <= r_err | (w_next == S_ERR);
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] r_instret;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instret <= '0;
      end else if (pc_wen) begin
         r_instret <= r_instret + 32'd1;
      end
   end

   assign instret = r_instret;
`else
   assign instret = '0;
`endif

   assign state  = r_state;
   assign halted = r_halted;
   assign err    = r_err;

endmodule

`default_nettype wire
